// File: rtl/eem16_pkg.sv
// Shared definitions for the score collector and the maxindex datapath it feeds.
// Letter index constants keep slot numbering and maxindex labels in one place.
package eem16_pkg;

  localparam int NUM_LETTERS = 26;
  localparam int SCORE_W     = 8;
  localparam int IDX_W       = 5;

  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } coll_state_e;

  localparam idx_t L_A = 5'd0,  L_B = 5'd1,  L_C = 5'd2,  L_D = 5'd3,  L_E = 5'd4;
  localparam idx_t L_F = 5'd5,  L_G = 5'd6,  L_H = 5'd7,  L_I = 5'd8,  L_J = 5'd9;
  localparam idx_t L_K = 5'd10, L_L = 5'd11, L_M = 5'd12, L_N = 5'd13, L_O = 5'd14;
  localparam idx_t L_P = 5'd15, L_Q = 5'd16, L_R = 5'd17, L_S = 5'd18, L_T = 5'd19;
  localparam idx_t L_U = 5'd20, L_V = 5'd21, L_W = 5'd22, L_X = 5'd23, L_Y = 5'd24;
  localparam idx_t L_Z = 5'd25;

endpackage

// File: rtl/score_collector_if.sv
// Serial score stream: one letter score per beat on a valid/ready handshake.
interface score_collector_if;
  import eem16_pkg::*;

  logic   in_valid;
  logic   in_ready;
  score_t in_score;
  logic   in_sof;

  modport master (output in_valid, in_score, in_sof, input  in_ready);
  modport slave  (input  in_valid, in_score, in_sof, output in_ready);

endinterface

// File: rtl/score_collector.sv
// Collects 26 serial letter scores into a frame, presents it on a..z and holds
// it until the consumer acknowledges with frame_ready.
module score_collector
  import eem16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  score_collector_if.slave s_in,
  output score_t           a, b, c, d, e, f, g, h, i, j, k, l, m,
  output score_t           n, o, p, q, r, s, t, u, v, w, x, y, z,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             frame_err
);

  coll_state_e r_state, w_state_nxt;
  idx_t        r_cnt,   w_cnt_nxt;
  idx_t        w_wr_idx;
  logic        r_err,   w_err_nxt;
  logic        w_wr_en;
  logic        w_accept;
  score_t      r_slot [NUM_LETTERS];

  // Handshake outputs decode registered state only; no input reaches them.
  assign s_in.in_ready = (r_state == FILL);
  assign frame_valid   = (r_state == FULL);
  assign frame_err     = r_err;
  assign w_accept      = s_in.in_valid & s_in.in_ready;

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_cnt;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          if (s_in.in_sof) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = L_A;
            w_cnt_nxt = IDX_W'(1);
            w_err_nxt = (r_cnt != L_A);
          end else if (r_cnt == L_A) begin
            w_err_nxt = 1'b1;
          end else begin
            w_wr_en = 1'b1;
            if (r_cnt == L_Z) begin
              w_cnt_nxt   = L_A;
              w_state_nxt = FULL;
            end else begin
              w_cnt_nxt = r_cnt + IDX_W'(1);
            end
          end
        end
      end
      FULL: begin
        if (frame_ready) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_cnt   <= L_A;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // NOTE: the slot array is reset because a..z must read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int idx = 0; idx < NUM_LETTERS; idx++) r_slot[idx] <= '0;
    end else if (w_wr_en) begin
      r_slot[w_wr_idx] <= s_in.in_score;
    end
  end

  assign a = r_slot[L_A];
  assign b = r_slot[L_B];
  assign c = r_slot[L_C];
  assign d = r_slot[L_D];
  assign e = r_slot[L_E];
  assign f = r_slot[L_F];
  assign g = r_slot[L_G];
  assign h = r_slot[L_H];
  assign i = r_slot[L_I];
  assign j = r_slot[L_J];
  assign k = r_slot[L_K];
  assign l = r_slot[L_L];
  assign m = r_slot[L_M];
  assign n = r_slot[L_N];
  assign o = r_slot[L_O];
  assign p = r_slot[L_P];
  assign q = r_slot[L_Q];
  assign r = r_slot[L_R];
  assign s = r_slot[L_S];
  assign t = r_slot[L_T];
  assign u = r_slot[L_U];
  assign v = r_slot[L_V];
  assign w = r_slot[L_W];
  assign x = r_slot[L_X];
  assign y = r_slot[L_Y];
  assign z = r_slot[L_Z];

endmodule

// File: tb/tb_score_collector.sv
// Scoreboard bench for score_collector: a beat-level model predicts frames,
// framing errors and handshake state; completed frames are compared on frame_valid.
module tb_score_collector;
  import eem16_pkg::*;

  typedef logic [NUM_LETTERS*SCORE_W-1:0] frame_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   frame_ready = 1'b0;
  logic   frame_valid;
  logic   frame_err;
  score_t dut_slot [NUM_LETTERS];

  score_collector_if bus ();

  int     n_vec = 0;
  int     n_bad = 0;
  frame_t sb_q [$];
  frame_t cur_exp = '0;
  logic   prev_fv = 1'b0;
  score_t m_slot [NUM_LETTERS];
  int     m_cnt = 0;
  bit     rdy_mode = 1'b0;
  logic   rdy_fixed = 1'b1;

  score_collector dut (
    .clk(clk), .rst(rst), .s_in(bus.slave),
    .a(dut_slot[0]),  .b(dut_slot[1]),  .c(dut_slot[2]),  .d(dut_slot[3]),
    .e(dut_slot[4]),  .f(dut_slot[5]),  .g(dut_slot[6]),  .h(dut_slot[7]),
    .i(dut_slot[8]),  .j(dut_slot[9]),  .k(dut_slot[10]), .l(dut_slot[11]),
    .m(dut_slot[12]), .n(dut_slot[13]), .o(dut_slot[14]), .p(dut_slot[15]),
    .q(dut_slot[16]), .r(dut_slot[17]), .s(dut_slot[18]), .t(dut_slot[19]),
    .u(dut_slot[20]), .v(dut_slot[21]), .w(dut_slot[22]), .x(dut_slot[23]),
    .y(dut_slot[24]), .z(dut_slot[25]),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Consumer: fixed or random acknowledge, changed well away from the edges.
  always @(posedge clk) begin
    #2;
    frame_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t dut_frame();
    frame_t fr;
    for (int li = 0; li < NUM_LETTERS; li++) fr[li*SCORE_W +: SCORE_W] = dut_slot[li];
    return fr;
  endfunction

  function automatic frame_t pack_model();
    frame_t fr;
    for (int li = 0; li < NUM_LETTERS; li++) fr[li*SCORE_W +: SCORE_W] = m_slot[li];
    return fr;
  endfunction

  function automatic int argmax(input frame_t fr);
    int best = 0;
    for (int li = 1; li < NUM_LETTERS; li++)
      if (fr[li*SCORE_W +: SCORE_W] > fr[best*SCORE_W +: SCORE_W]) best = li;
    return best;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int li = 0; li < NUM_LETTERS; li++) m_slot[li] = '0;
    sb_q.delete();
  endtask

  // Frame monitor: pop on frame_valid rise, then hold-check every FULL cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_fv = 1'b0;
    end else begin
      if (frame_valid && !prev_fv) begin
        check("sb_pending", 256'(sb_q.size() > 0), 256'(1));
        if (sb_q.size() > 0) begin
          cur_exp = sb_q.pop_front();
          check("argmax", 256'(argmax(dut_frame())), 256'(argmax(cur_exp)));
        end
      end
      if (frame_valid) begin
        check("frame_hold", 256'(dut_frame()), 256'(cur_exp));
        check("in_ready_full", 256'(bus.in_ready), 256'(0));
      end
      prev_fv = frame_valid;
    end
  end

  // Called between a rising edge and the following falling edge.
  task automatic send_beat(input score_t sc, input logic sof, output int waits);
    logic exp_err;
    logic last;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_score = sc;
    bus.in_sof   = sof;
    @(negedge clk);
    while (!bus.in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 256'(bus.in_ready), 256'(1));
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    exp_err = 1'b0;
    last    = 1'b0;
    if (sof) begin
      exp_err   = (m_cnt != 0);
      m_slot[0] = sc;
      m_cnt     = 1;
    end else if (m_cnt == 0) begin
      exp_err = 1'b1;
    end else begin
      m_slot[m_cnt] = sc;
      if (m_cnt == NUM_LETTERS - 1) begin
        m_cnt = 0;
        last  = 1'b1;
        sb_q.push_back(pack_model());
      end else begin
        m_cnt++;
      end
    end
    check("frame_err", 256'(frame_err), 256'(exp_err));
    check("frame_valid", 256'(frame_valid), 256'(last));
    check("in_ready", 256'(bus.in_ready), 256'(!last));
  endtask

  task automatic send_frame(input bit gapped);
    int wt;
    for (int bi = 0; bi < NUM_LETTERS; bi++) begin
      send_beat(score_t'($urandom_range(0, 255)), bi == 0, wt);
      if (gapped) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_slots"}, 256'(dut_frame()), 256'(0));
    check({tag, "_fv"}, 256'(frame_valid), 256'(0));
    check({tag, "_err"}, 256'(frame_err), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    bus.in_valid = 1'b0;
    bus.in_score = '0;
    bus.in_sof   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 256'(bus.in_ready), 256'(1));

    // Full frame with ready held high: scores 10..35.
    rdy_fixed = 1'b1;
    for (int bi = 0; bi < NUM_LETTERS; bi++) send_beat(score_t'(10 + bi), bi == 0, wt);
    check("full_a", 256'(dut_slot[0]), 256'(10));
    check("full_z", 256'(dut_slot[25]), 256'(35));
    check("full_argmax", 256'(argmax(dut_frame())), 256'(25));
    @(posedge clk);
    #1;
    check("full_fv_drop", 256'(frame_valid), 256'(0));
    check("full_ready_back", 256'(bus.in_ready), 256'(1));

    // Missing SOF at cnt 0: dropped, slot 0 keeps the previous frame's value.
    send_beat(8'd77, 1'b0, wt);
    check("miss_sof_slot0", 256'(dut_slot[0]), 256'(m_slot[0]));

    // Backpressure: frame held for 10 cycles with a beat waiting.
    rdy_fixed = 1'b0;
    for (int bi = 0; bi < NUM_LETTERS; bi++) send_beat(score_t'(100 + bi), bi == 0, wt);
    bus.in_valid = 1'b1;
    bus.in_score = 8'd1;
    bus.in_sof   = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", 256'(bus.in_ready), 256'(0));
    end
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    send_beat(8'd1, 1'b1, wt);
    check("bp_wait", 256'(wt), 256'(1));

    // Resync: 5 beats total, then a second SOF with 99, then 25 more beats.
    for (int bi = 1; bi < 5; bi++) send_beat(score_t'(50 + bi), 1'b0, wt);
    send_beat(8'd99, 1'b1, wt);
    for (int bi = 1; bi < NUM_LETTERS; bi++) send_beat(score_t'(200 + bi), 1'b0, wt);
    check("resync_a", 256'(dut_slot[0]), 256'(99));

    // Reset at cnt 13.
    for (int bi = 0; bi < 13; bi++) send_beat(score_t'(60 + bi), bi == 0, wt);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_err_quiet", 256'(frame_err), 256'(0));
    send_frame(1'b0);

    // Reset while holding a frame in FULL.
    @(posedge clk);
    #1;
    rdy_fixed = 1'b0;
    send_frame(1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_full");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rdy_fixed = 1'b1;
    @(posedge clk);
    #1;
    check("rst_full_ready", 256'(bus.in_ready), 256'(1));
    send_frame(1'b0);

    // Gapped input with a random consumer.
    rdy_mode = 1'b1;
    repeat (3) send_frame(1'b1);
    rdy_mode  = 1'b0;
    rdy_fixed = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 256'(sb_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
